// File: rtl/dense_out_serializer.sv
// Requantizes a dense layer's NUM_TREES 32-bit results to 8-bit pixels and
// serializes them, tree 0 first, onto a ready/valid byte stream.
// Optional build macro: DENSE_SER_ROUND_EN adds round-half-up before the shift.

module dense_ser_requant #(
  parameter int SHIFT = 3
) (
  input  logic [31:0] word,
  output logic [7:0]  pixel,
  output logic        sat
);
  logic signed [32:0] v_ext;
  logic signed [32:0] q;

`ifdef DENSE_SER_ROUND_EN
  // Widened to 33 bits so adding the half-LSB can never wrap a large positive word.
  localparam logic signed [32:0] RND = (SHIFT == 0) ? 33'sd0 :
                                       (33'sd1 <<< ((SHIFT == 0) ? 0 : SHIFT - 1));
`else
  localparam logic signed [32:0] RND = 33'sd0;
`endif

  always_comb begin
    v_ext = $signed({word[31], word}) + RND;
    q     = v_ext >>> SHIFT;
    pixel = q[7:0];
    sat   = 1'b0;
    if (q[32]) begin
      pixel = 8'd0;
    end else if (|q[31:8]) begin
      pixel = 8'd255;
      sat   = 1'b1;
    end
  end
endmodule

module dense_out_serializer #(
  parameter int NUM_TREES = 2,
  parameter int SHIFT     = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [32*NUM_TREES-1:0]   pixel_vector_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                pixel_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [15:0]               sat_count
);
  localparam int IW = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_TREES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                  state;
  logic [IW-1:0]               idx;
  logic [IW-1:0]               idx_inc;
  logic [NUM_TREES-1:0][7:0]   buf_q;
  logic [NUM_TREES-1:0][7:0]   pix_n;
  logic [NUM_TREES-1:0]        sat_n;
  logic [16:0]                 sat_add;
  logic [16:0]                 sat_sum;
  logic [15:0]                 sat_nxt;
  logic                        accept;

  genvar k;
  generate
    for (k = 0; k < NUM_TREES; k++) begin : g_lane
      dense_ser_requant #(.SHIFT(SHIFT)) u_rq (
        .word  (pixel_vector_in[32*k +: 32]),
        .pixel (pix_n[k]),
        .sat   (sat_n[k])
      );
    end
  endgenerate

  assign in_ready = (state == IDLE) | ((state == SEND) & out_last & out_ready);
  assign accept   = in_valid & in_ready;
  assign idx_inc  = idx + 1'b1;

  // Several lanes may clamp in the same vector; the count saturates rather than wraps.
  always_comb begin
    sat_add = '0;
    for (int i = 0; i < NUM_TREES; i++) sat_add = sat_add + 17'(sat_n[i]);
    sat_sum = {1'b0, sat_count} + sat_add;
    sat_nxt = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      buf_q     <= '0;
      pixel_out <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat_count <= 16'd0;
    end else if (accept) begin
      // Also covers the last-pixel handshake, so a new vector follows with no bubble.
      state     <= SEND;
      idx       <= '0;
      buf_q     <= pix_n;
      pixel_out <= pix_n[0];
      out_valid <= 1'b1;
      out_last  <= (NUM_TREES == 1);
      sat_count <= sat_nxt;
    end else if (state == SEND && out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        idx       <= idx_inc;
        pixel_out <= buf_q[idx_inc];
        out_last  <= (idx_inc == LAST);
      end
    end
  end
endmodule
